// File: rtl/synth_pkg.sv
// Shared synth types: envelope states, rate/sustain tables
// and amp_envelope field positions.
package synth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } env_state_t;

  localparam int ENV_CODE_W = 2;
  localparam int ATK_LSB    = 0;
  localparam int DEC_LSB    = 2;
  localparam int SUS_LSB    = 4;
  localparam int REL_LSB    = 6;

  localparam logic [7:0] SUSTAIN_LVL [4] = '{
    8'h40, 8'h80, 8'hC0, 8'hFF
  };

  // Larger code gives a slower slope.
  function automatic logic [3:0] rate_step(
    input logic [1:0] code
  );
    return 4'd8 >> code;
  endfunction

endpackage

// File: rtl/env_tick_gen.sv
// Free-running envelope prescaler; one-cycle tick
// every TICK_DIV clocks.
module env_tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope with registered VCA scaling
// of the oscillator sample stream.
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int SAMPLE_W = 12
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       gate,
  input  logic [7:0]                 amp_envelope,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_out_valid,
  output logic [7:0]                 env_level,
  output logic                       env_active
);

  localparam int PW = SAMPLE_W + 9;

  env_state_t state;
  logic       tick;
  logic       gate_q;
  logic       seen_low;
  logic       rise;
  logic       fall;
  logic [3:0] atk_s;
  logic [3:0] dec_s;
  logic [3:0] rel_s;
  logic [7:0] tgt;
  logic [8:0] up_sum;
  logic [8:0] dec_floor;
  logic [7:0] dec_next;
  logic [7:0] rel_next;

  env_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick)
  );

  assign atk_s = rate_step(amp_envelope[ATK_LSB +: ENV_CODE_W]);
  assign dec_s = rate_step(amp_envelope[DEC_LSB +: ENV_CODE_W]);
  assign rel_s = rate_step(amp_envelope[REL_LSB +: ENV_CODE_W]);
  assign tgt   = SUSTAIN_LVL[amp_envelope[SUS_LSB +: ENV_CODE_W]];

  // A gate held through reset must drop before it can retrigger.
  assign rise = gate & ~gate_q & seen_low;
  assign fall = ~gate & gate_q;

  assign up_sum    = {1'b0, env_level} + {5'b0, atk_s};
  assign dec_floor = {1'b0, tgt} + {5'b0, dec_s};
  assign dec_next  = env_level - {4'b0, dec_s};
  assign rel_next  = env_level - {4'b0, rel_s};

  assign env_active = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      env_level <= '0;
      gate_q    <= 1'b0;
      seen_low  <= 1'b0;
    end else begin
      gate_q <= gate;
      if (!gate) begin
        seen_low <= 1'b1;
      end
      if (rise) begin
        state <= ATTACK;
      end else if (fall && (state == ATTACK ||
                            state == DECAY  ||
                            state == SUSTAIN)) begin
        state <= RELEASE;
      end else if (tick) begin
        case (state)
          ATTACK: begin
            if (up_sum >= 9'd255) begin
              env_level <= 8'hFF;
              state     <= DECAY;
            end else begin
              env_level <= up_sum[7:0];
            end
          end
          DECAY: begin
            if ({1'b0, env_level} <= dec_floor) begin
              env_level <= tgt;
              state     <= SUSTAIN;
            end else begin
              env_level <= dec_next;
            end
          end
          SUSTAIN: begin
            env_level <= tgt;
          end
          RELEASE: begin
            if (env_level <= {4'b0, rel_s}) begin
              env_level <= '0;
              state     <= IDLE;
            end else begin
              env_level <= rel_next;
            end
          end
          default: begin
            env_level <= '0;
          end
        endcase
      end
    end
  end

  logic signed [PW-1:0] s_ext;
  logic signed [PW-1:0] l_ext;
  logic signed [PW-1:0] product;
  logic                 unused_bits;

  assign s_ext       = PW'(sample_in);
  assign l_ext       = PW'({1'b0, env_level});
  assign product     = s_ext * l_ext;
  assign unused_bits = ^{product[PW-1], product[7:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_out       <= '0;
      sample_out_valid <= 1'b0;
    end else begin
      sample_out_valid <= sample_valid;
      if (sample_valid) begin
        sample_out <= product[SAMPLE_W+7:8];
      end
    end
  end

endmodule

// File: doc/adsr_envelope.md
# adsr_envelope

Amplitude envelope generator and VCA stage, directly downstream of `keypad_decoder`. It consumes the 8-bit `amp_envelope` control word (attack, decay, sustain and release codes) and a note gate. It runs a five-state ADSR machine on a prescaled tick and scales the oscillator sample stream by the current envelope level. Its output feeds the filter/DAC path.

## Interface
Parameters:
- `TICK_DIV`, default 1000: clk cycles per envelope tick; legal range ≥2.
- `SAMPLE_W`, default 12: signed audio sample width.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous and active-low.
- `gate` in 1: note held; synchronous to `clk`.
- `amp_envelope` in 8: `[1:0]` attack code, `[3:2]` decay code, `[5:4]` sustain code, `[7:6]` release code.
- `sample_in` in SAMPLE_W: signed oscillator sample.
- `sample_valid` in 1: `sample_in` qualifier.
- `sample_out` out SAMPLE_W: signed scaled sample.
- `sample_out_valid` out 1: `sample_out` qualifier.
- `env_level` out 8: current envelope level, unsigned.
- `env_active` out 1: high whenever state ≠ IDLE.

## Operation
- Rate codes (attack, decay, release): step = 8 >> code, so code 0→8, 1→4, 2→2, 3→1. A larger code means a slower slope.
- Sustain code maps to a target level: 0→0x40, 1→0x80, 2→0xC0, 3→0xFF.
- Codes are sampled live on every tick and are never latched per note.
- Gate edges come from `gate` vs registered `gate_q`:
  - rise = `gate & ~gate_q`
  - fall = `~gate & gate_q`
- States are IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- Gate edges, from any state:
  - Rise → ATTACK. The level is not reset; retrigger continues from the current level.
  - Fall in ATTACK, DECAY or SUSTAIN → RELEASE.
  - Fall in IDLE or RELEASE is ignored.
- Per tick, when no gate edge occurs the same cycle:
  - ATTACK: level += attack step, saturating at 0xFF. When level reaches 0xFF, go to DECAY.
  - DECAY: level −= decay step, clamped at the sustain target. When level equals the target, go to SUSTAIN. If level is already ≤ target on entry, level jumps to the target and goes to SUSTAIN on that tick.
  - SUSTAIN: level = sustain target; tracks live code changes on the next tick.
  - RELEASE: level −= release step, clamped at 0. When level reaches 0, go to IDLE.
  - IDLE: level holds 0.
- A gate edge and a tick in the same cycle: the edge wins. The state changes, level is unchanged, and that tick is consumed.
- Arithmetic:
  - Level math uses a 9-bit intermediate; saturate/clamp before writeback.
  - VCA product = `sample_in` × signed{1'b0, `env_level`}, a (SAMPLE_W+9)-bit signed value.
  - `sample_out` = product >>> 8, truncated to SAMPLE_W. It never overflows because level ≤ 255.

## Timing
- Reset values: state IDLE, `env_level` 0, `env_active` 0, `sample_out` 0, `sample_out_valid` 0, `gate_q` 0, prescaler count 0.
- Prescaler:
  - Free-running 0..TICK_DIV−1.
  - Tick is asserted for one cycle when count = TICK_DIV−1, so the first tick comes TICK_DIV cycles after reset release.
  - Gate edges do not restart it.
- Gate to state: `gate` is first sampled high at clock edge N, and state/`env_active` show ATTACK after edge N.
- Level update: registered. `env_level` changes only after a tick edge.
- VCA latency is 1 cycle. `sample_out_valid` = `sample_valid` delayed 1 cycle, using the `env_level` value present in the input cycle. No backpressure.
- Reset asserted mid-note: all outputs return to reset values immediately (asynchronous). After release, the block waits for a fresh gate rise; a gate held high through reset does not trigger until it falls and rises again.

## Structure
- Shared package `synth_pkg` holds:
  - `env_state_t` enum.
  - `rate_step(code)` function.
  - `SUSTAIN_LVL[4]` constant array.
  - Field-slice localparams for `amp_envelope`, shared with `keypad_decoder` consumers.
- Sub-module `env_tick_gen` (parameter `TICK_DIV`; ports `clk`, `reset_n`, `tick`).
- The FSM, level datapath and VCA register live in `adsr_envelope`.

## Test plan
Run with TICK_DIV=4.
- Reset: assert `reset_n`=0 mid-sim → all outputs 0 within the same cycle; state IDLE after release.
- Full cycle, `amp_envelope`=8'b11_10_01_00:
  - Gate rise → ATTACK; 0xFF after 32 ticks.
  - DECAY 0xFF→0xC0 in 16 ticks (clamps from 0xC3).
  - SUSTAIN 0xC0.
  - Gate fall → RELEASE; 0 after 192 ticks → IDLE, `env_active`=0.
- Retrigger: gate fall at level 0x80 in RELEASE, then rise before 0 → ATTACK from the current level (0x80 minus any ticks elapsed), with no drop to 0.
- Edge/tick collision: gate rise in the same cycle as a tick → state ATTACK, level unchanged that cycle; first increment on the next tick.
- VCA:
  - level 0x80, `sample_in`=−2048, `sample_valid` pulse → next cycle `sample_out`=−1024, `sample_out_valid`=1.
  - level 0xFF, `sample_in`=2047 → 2039.
- Live sustain change: in SUSTAIN change code 2→0 → `env_level` becomes 0x40 on the next tick.
